// File: rtl/irq_or_collector_if.sv
// rtl/irq_or_collector_if.sv - request/mask/ack and interrupt status bundle for irq_or_collector
interface irq_or_collector_if #(
   parameter int WIDTH   = 4,
   parameter int COUNT_W = 8
);
   logic [WIDTH-1:0]   inReq;
   logic [WIDTH-1:0]   inMask;
   logic               inAck;
   logic               outIrq;
   logic [WIDTH-1:0]   outPending;
   logic [WIDTH-1:0]   outCause;
   logic               outSpurious;
   logic [COUNT_W-1:0] outCount;

   modport master (
      output inReq, inMask, inAck,
      input  outIrq, outPending, outCause, outSpurious, outCount
   );

   modport slave (
      input  inReq, inMask, inAck,
      output outIrq, outPending, outCause, outSpurious, outCount
   );
endinterface

// File: rtl/irq_or_collector.sv
// rtl/irq_or_collector.sv - edge-captured sticky pending bits merged into one acked, held-off interrupt
module or_gate (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);
   assign o_y = i_a | i_b;
endmodule

module irq_or_collector #(
   parameter int WIDTH   = 4,
   parameter int HOLDOFF = 2,
   parameter int COUNT_W = 8
) (
   input  logic inClk,
   input  logic inRstN,
   irq_or_collector_if.slave bus
);
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   state_t             r_state;
   logic [HW-1:0]      r_hold_cnt;
   logic               r_irq;
   logic               r_spurious;
   logic [WIDTH-1:0]   r_prev_req;
   logic [WIDTH-1:0]   r_pending;
   logic [WIDTH-1:0]   r_cause;
   logic [COUNT_W-1:0] r_count;

   logic [WIDTH-1:0]   w_edge;
   logic [WIDTH-1:0]   w_masked;
   logic [WIDTH-1:0]   w_or;
   logic               w_any;
   logic               w_accept;
   logic [WIDTH-1:0]   w_clear;

   assign w_edge   = bus.inReq & ~r_prev_req;
   assign w_masked = r_pending & bus.inMask;

   // Linear chain of 2-input ORs; w_or[WIDTH-1] is the reduction of all masked pending bits.
   assign w_or[0] = w_masked[0];
   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_or
         or_gate u_or (
            .i_a (w_or[gi-1]),
            .i_b (w_masked[gi]),
            .o_y (w_or[gi])
         );
      end
   endgenerate
   assign w_any = w_or[WIDTH-1];

   assign w_accept = (r_state == ST_ASSERT) && bus.inAck;
   assign w_clear  = w_accept ? w_masked : '0;

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         r_prev_req <= '0;
         r_pending  <= '0;
         r_count    <= '0;
      end else begin
         r_prev_req <= bus.inReq;
         // A fresh edge re-sets its bit even while the ack clears it.
         r_pending  <= (r_pending & ~w_clear) | w_edge;
         if ((|w_edge) && (r_count != {COUNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         r_state    <= ST_IDLE;
         r_hold_cnt <= '0;
         r_irq      <= 1'b0;
         r_spurious <= 1'b0;
         r_cause    <= '0;
      end else begin
         r_spurious <= bus.inAck && (r_state != ST_ASSERT);
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state <= ST_ASSERT;
                  r_irq   <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (bus.inAck) begin
                  r_state    <= ST_HOLDOFF;
                  r_irq      <= 1'b0;
                  r_hold_cnt <= HOLD_INIT;
                  r_cause    <= w_masked;
               end else if (!w_any) begin
                  r_state <= ST_IDLE;
                  r_irq   <= 1'b0;
               end
            end
            ST_HOLDOFF: begin
               if (r_hold_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_irq   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.outIrq      = r_irq;
   assign bus.outPending  = r_pending;
   assign bus.outCause    = r_cause;
   assign bus.outSpurious = r_spurious;
   assign bus.outCount    = r_count;
endmodule

// File: tb/tb_irq_or_collector.sv
// tb/tb_irq_or_collector.sv - directed self-checking bench for irq_or_collector
module tb_irq_or_collector;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   irq_or_collector_if #(.WIDTH(4), .COUNT_W(8)) ifa ();
   irq_or_collector_if #(.WIDTH(4), .COUNT_W(2)) ifb ();

   irq_or_collector #(.WIDTH(4), .HOLDOFF(2), .COUNT_W(8)) dut_a (
      .inClk (clk), .inRstN (rst_n), .bus (ifa.slave)
   );
   irq_or_collector #(.WIDTH(4), .HOLDOFF(2), .COUNT_W(2)) dut_b (
      .inClk (clk), .inRstN (rst_n), .bus (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ifa.inReq = '0; ifa.inMask = '0; ifa.inAck = 1'b0;
      ifb.inReq = '0; ifb.inMask = '0; ifb.inAck = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ifa.inReq = 4'hF; ifa.inMask = 4'h0; ifa.inAck = 1'b0;
      ifb.inReq = '0; ifb.inMask = '0; ifb.inAck = 1'b0;
      tick();
      tick();
      total++; if (ifa.outPending !== 4'h0) begin bad++; $display("FAIL t1_pend_rst got=%0h exp=0", ifa.outPending); end
      total++; if (ifa.outCount !== 8'h0) begin bad++; $display("FAIL t1_cnt_rst got=%0h exp=0", ifa.outCount); end
      total++; if ({ifa.outIrq, ifa.outSpurious, ifa.outCause} !== 6'h0) begin bad++; $display("FAIL t1_misc_rst got=%0h exp=0", {ifa.outIrq, ifa.outSpurious, ifa.outCause}); end
      rst_n = 1'b1;
      tick();
      total++; if (ifa.outPending !== 4'hF) begin bad++; $display("FAIL t1_pend_first got=%0h exp=f", ifa.outPending); end
      total++; if (ifa.outCount !== 8'd1) begin bad++; $display("FAIL t1_cnt_first got=%0d exp=1", ifa.outCount); end
      tick();
      total++; if (ifa.outIrq !== 1'b0) begin bad++; $display("FAIL t1_irq_masked got=%0b exp=0", ifa.outIrq); end
   endtask

   task automatic test_ack_holdoff();
      do_reset();
      ifa.inMask = 4'h2;
      ifa.inReq  = 4'h2;
      tick();
      ifa.inReq = 4'h0;
      total++; if ({ifa.outPending, ifa.outIrq} !== {4'h2, 1'b0}) begin bad++; $display("FAIL t2_n1 got=%0h exp=4", {ifa.outPending, ifa.outIrq}); end
      tick();
      total++; if (ifa.outIrq !== 1'b1) begin bad++; $display("FAIL t2_irq_n2 got=%0b exp=1", ifa.outIrq); end
      ifa.inAck = 1'b1;
      tick();
      ifa.inAck = 1'b0;
      total++; if (ifa.outCause !== 4'h2) begin bad++; $display("FAIL t2_cause got=%0h exp=2", ifa.outCause); end
      total++; if (ifa.outPending !== 4'h0) begin bad++; $display("FAIL t2_pend_clr got=%0h exp=0", ifa.outPending); end
      total++; if ({ifa.outIrq, ifa.outSpurious} !== 2'b00) begin bad++; $display("FAIL t2_after_ack got=%0b exp=0", {ifa.outIrq, ifa.outSpurious}); end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (ifa.outIrq !== 1'b0) begin bad++; $display("FAIL t2_stay_low c%0d got=%0b exp=0", i, ifa.outIrq); end
      end
      total++; if (ifa.outCause !== 4'h2) begin bad++; $display("FAIL t2_cause_hold got=%0h exp=2", ifa.outCause); end
      total++; if (ifa.outCount !== 8'd1) begin bad++; $display("FAIL t2_cnt got=%0d exp=1", ifa.outCount); end
   endtask

   task automatic test_edge_with_ack();
      do_reset();
      ifa.inMask = 4'h2;
      ifa.inReq  = 4'h2;
      tick();
      ifa.inReq = 4'h0;
      tick();
      ifa.inAck = 1'b1;
      ifa.inReq = 4'h2;
      tick();
      ifa.inAck = 1'b0;
      ifa.inReq = 4'h0;
      total++; if (ifa.outPending !== 4'h2) begin bad++; $display("FAIL t3_pend_kept got=%0h exp=2", ifa.outPending); end
      total++; if ({ifa.outIrq, ifa.outCause} !== {1'b0, 4'h2}) begin bad++; $display("FAIL t3_ack got=%0h exp=2", {ifa.outIrq, ifa.outCause}); end
      tick();
      total++; if (ifa.outIrq !== 1'b0) begin bad++; $display("FAIL t3_hold2 got=%0b exp=0", ifa.outIrq); end
      tick();
      total++; if (ifa.outIrq !== 1'b0) begin bad++; $display("FAIL t3_idle got=%0b exp=0", ifa.outIrq); end
      tick();
      total++; if (ifa.outIrq !== 1'b1) begin bad++; $display("FAIL t3_reassert got=%0b exp=1", ifa.outIrq); end
      total++; if (ifa.outCount !== 8'd2) begin bad++; $display("FAIL t3_cnt got=%0d exp=2", ifa.outCount); end
   endtask

   task automatic test_spurious();
      do_reset();
      ifa.inReq = 4'h1;
      tick();
      ifa.inReq = 4'h0;
      total++; if (ifa.outPending !== 4'h1) begin bad++; $display("FAIL t4_pend got=%0h exp=1", ifa.outPending); end
      tick();
      tick();
      total++; if (ifa.outIrq !== 1'b0) begin bad++; $display("FAIL t4_irq got=%0b exp=0", ifa.outIrq); end
      ifa.inAck = 1'b1;
      tick();
      ifa.inAck = 1'b0;
      total++; if (ifa.outSpurious !== 1'b1) begin bad++; $display("FAIL t4_spur got=%0b exp=1", ifa.outSpurious); end
      total++; if ({ifa.outPending, ifa.outCause} !== {4'h1, 4'h0}) begin bad++; $display("FAIL t4_unchanged got=%0h exp=10", {ifa.outPending, ifa.outCause}); end
      tick();
      total++; if (ifa.outSpurious !== 1'b0) begin bad++; $display("FAIL t4_spur_end got=%0b exp=0", ifa.outSpurious); end
   endtask

   task automatic test_mask_drop();
      do_reset();
      ifa.inMask = 4'h8;
      ifa.inReq  = 4'h9;
      tick();
      ifa.inReq = 4'h0;
      tick();
      total++; if (ifa.outIrq !== 1'b1) begin bad++; $display("FAIL t7_irq got=%0b exp=1", ifa.outIrq); end
      ifa.inMask = 4'h0;
      tick();
      total++; if (ifa.outIrq !== 1'b0) begin bad++; $display("FAIL t7_drop got=%0b exp=0", ifa.outIrq); end
      ifa.inAck = 1'b1;
      tick();
      ifa.inAck = 1'b0;
      total++; if ({ifa.outSpurious, ifa.outPending} !== {1'b1, 4'h9}) begin bad++; $display("FAIL t7_ack_idle got=%0h exp=19", {ifa.outSpurious, ifa.outPending}); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         ifb.inReq = 4'h1;
         tick();
         ifb.inReq = 4'h0;
         tick();
         if (i == 1) begin
            total++; if (ifb.outCount !== 2'd2) begin bad++; $display("FAIL t5_cnt2 got=%0d exp=2", ifb.outCount); end
         end
         if (i == 2) begin
            total++; if (ifb.outCount !== 2'd3) begin bad++; $display("FAIL t5_cnt3 got=%0d exp=3", ifb.outCount); end
         end
      end
      total++; if (ifb.outCount !== 2'd3) begin bad++; $display("FAIL t5_sat got=%0d exp=3", ifb.outCount); end
   endtask

   task automatic test_reset_holdoff();
      do_reset();
      ifa.inMask = 4'h1;
      ifa.inReq  = 4'h1;
      tick();
      ifa.inReq = 4'h0;
      tick();
      ifa.inAck = 1'b1;
      tick();
      ifa.inAck = 1'b0;
      total++; if (ifa.outCause !== 4'h1) begin bad++; $display("FAIL t6_cause_pre got=%0h exp=1", ifa.outCause); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({ifa.outIrq, ifa.outSpurious, ifa.outPending, ifa.outCause, ifa.outCount} !== 18'h0) begin bad++; $display("FAIL t6_async got=%0h exp=0", {ifa.outIrq, ifa.outSpurious, ifa.outPending, ifa.outCause, ifa.outCount}); end
      tick();
      rst_n = 1'b1;
      ifa.inReq = 4'h1;
      tick();
      ifa.inReq = 4'h0;
      total++; if (ifa.outIrq !== 1'b0) begin bad++; $display("FAIL t6_n1 got=%0b exp=0", ifa.outIrq); end
      tick();
      total++; if (ifa.outIrq !== 1'b1) begin bad++; $display("FAIL t6_idle_n2 got=%0b exp=1", ifa.outIrq); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      test_reset();
      test_ack_holdoff();
      test_edge_with_ack();
      test_spurious();
      test_mask_drop();
      test_saturate();
      test_reset_holdoff();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
